// File: rtl/arm_pkg.sv
// Shared ARM definitions: condition codes, ALU command encodings and NZCV bit positions.
// Used by the ID/EX register and by status-evaluation logic elsewhere in the core.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_MOV = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_ADC = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SBC = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_ORR = 4'b0111;
    localparam logic [3:0] ALU_EOR = 4'b1000;
    localparam logic [3:0] ALU_MVN = 4'b1001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_en;
        logic branch;
        logic status_en;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: 1'b0};

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation: cond field + NZCV flags -> pass.
// Encoding 1111 is treated as "never".
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond_in,
    input  logic [3:0] flags,
    output logic       cond_pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (cond_in)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with ARM condition gating, hazard freeze and branch flush.
// Optional macro STATUS_FWD_EN adds same-cycle flag forwarding from the EX stage.
module id_ex_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic [3:0]         cond_in,
    input  logic [3:0]         status_in,
`ifdef STATUS_FWD_EN
    input  logic               ex_status_wr,
    input  logic [3:0]         ex_status_val,
`endif
    input  logic [3:0]         alu_cmd_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               wb_en_in,
    input  logic               branch_in,
    input  logic               status_en_in,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  val_rn_in,
    input  logic [DATA_W-1:0]  val_rm_in,
    input  logic               imm_in,
    input  logic [11:0]        shift_op_in,
    input  logic [23:0]        simm24_in,
    input  logic [RADDR_W-1:0] dest_in,
    input  logic [RADDR_W-1:0] src1_in,
    input  logic [RADDR_W-1:0] src2_in,
    output logic [3:0]         alu_cmd_out,
    output logic               mem_read_out,
    output logic               mem_write_out,
    output logic               wb_en_out,
    output logic               branch_out,
    output logic               status_en_out,
    output logic               carry_out,
    output logic [DATA_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  val_rn_out,
    output logic [DATA_W-1:0]  val_rm_out,
    output logic               imm_out,
    output logic [11:0]        shift_op_out,
    output logic [23:0]        simm24_out,
    output logic [RADDR_W-1:0] dest_out,
    output logic [RADDR_W-1:0] src1_out,
    output logic [RADDR_W-1:0] src2_out,
    output logic               valid_out
);

    logic [3:0] flags_p0;
    logic       cond_pass_p0;
    ctrl_t      ctrl_in_p0;
    ctrl_t      ctrl_gated_p0;

    logic [3:0]         alu_cmd_p1;
    ctrl_t              ctrl_p1;
    logic               carry_p1;
    logic               vld_p1;
    logic [DATA_W-1:0]  pc_p1;
    logic [DATA_W-1:0]  val_rn_p1;
    logic [DATA_W-1:0]  val_rm_p1;
    logic               imm_p1;
    logic [11:0]        shift_op_p1;
    logic [23:0]        simm24_p1;
    logic [RADDR_W-1:0] dest_p1;
    logic [RADDR_W-1:0] src1_p1;
    logic [RADDR_W-1:0] src2_p1;

    // Stage p0: flag source selection and condition evaluation
`ifdef STATUS_FWD_EN
    assign flags_p0 = ex_status_wr ? ex_status_val : status_in;
`else
    assign flags_p0 = status_in;
`endif

    cond_check u_cond_check (
        .cond_in   (cond_in),
        .flags     (flags_p0),
        .cond_pass (cond_pass_p0)
    );

    assign ctrl_in_p0 = '{
        mem_read:  mem_read_in,
        mem_write: mem_write_in,
        wb_en:     wb_en_in,
        branch:    branch_in,
        status_en: status_en_in
    };

    // A failed condition keeps operands and ALU command but squashes every side effect.
    assign ctrl_gated_p0 = cond_pass_p0 ? ctrl_in_p0 : CTRL_NONE;

    // Stage p1: the ID/EX register; rst and flush both produce an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_cmd_p1  <= ALU_NOP;
            ctrl_p1     <= CTRL_NONE;
            carry_p1    <= 1'b0;
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            val_rn_p1   <= '0;
            val_rm_p1   <= '0;
            imm_p1      <= 1'b0;
            shift_op_p1 <= '0;
            simm24_p1   <= '0;
            dest_p1     <= '0;
            src1_p1     <= '0;
            src2_p1     <= '0;
        end else if (!freeze) begin
            alu_cmd_p1  <= alu_cmd_in;
            ctrl_p1     <= ctrl_gated_p0;
            carry_p1    <= flags_p0[FLAG_C];
            vld_p1      <= cond_pass_p0;
            pc_p1       <= pc_in;
            val_rn_p1   <= val_rn_in;
            val_rm_p1   <= val_rm_in;
            imm_p1      <= imm_in;
            shift_op_p1 <= shift_op_in;
            simm24_p1   <= simm24_in;
            dest_p1     <= dest_in;
            src1_p1     <= src1_in;
            src2_p1     <= src2_in;
        end
    end

    assign alu_cmd_out   = alu_cmd_p1;
    assign mem_read_out  = ctrl_p1.mem_read;
    assign mem_write_out = ctrl_p1.mem_write;
    assign wb_en_out     = ctrl_p1.wb_en;
    assign branch_out    = ctrl_p1.branch;
    assign status_en_out = ctrl_p1.status_en;
    assign carry_out     = carry_p1;
    assign valid_out     = vld_p1;
    assign pc_out        = pc_p1;
    assign val_rn_out    = val_rn_p1;
    assign val_rm_out    = val_rm_p1;
    assign imm_out       = imm_p1;
    assign shift_op_out  = shift_op_p1;
    assign simm24_out    = simm24_p1;
    assign dest_out      = dest_p1;
    assign src1_out      = src1_p1;
    assign src2_out      = src2_p1;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register. Sits directly downstream of the ID-stage control unit and register file, and feeds the EX stage.
- Evaluates the instruction's ARM condition field against the current NZCV flags.
- Captures the control word plus operands each cycle. A failed condition becomes a bubble.
- Supports hazard freeze and branch flush.

Parameters:
- DATA_W, 32, width of PC and register operands.
- RADDR_W, 4, register-file address width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard stall; hold all outputs
- flush  in  1  branch taken in EX; insert bubble
- cond_in  in  4  instruction condition field [31:28]
- status_in  in  4  NZCV from status register {N,Z,C,V}
- alu_cmd_in  in  4  ALU command from control unit
- mem_read_in, mem_write_in, wb_en_in, branch_in, status_en_in  in  1 each  control bits
- pc_in  in  DATA_W  PC+4 of instruction
- val_rn_in, val_rm_in  in  DATA_W  register operands
- imm_in  in  1  instruction bit 25
- shift_op_in  in  12  shifter operand
- simm24_in  in  24  branch offset
- dest_in, src1_in, src2_in  in  RADDR_W  register indices
- alu_cmd_out  out  4  registered
- mem_read_out, mem_write_out, wb_en_out, branch_out, status_en_out  out  1 each  registered, condition-gated
- carry_out  out  1  registered C flag for ADC/SBC
- pc_out, val_rn_out, val_rm_out  out  DATA_W  registered
- imm_out, shift_op_out, simm24_out, dest_out, src1_out, src2_out  out  as inputs  registered
- valid_out  out  1  1 = real instruction in EX, 0 = bubble

Behaviour:
- Update priority each rising edge: rst > flush > freeze > load.
- Reset: all outputs 0, including valid_out=0 and alu_cmd_out=0000.
- Flush:
  - Control bits, alu_cmd_out and valid_out go to 0.
  - Data fields also cleared to 0, giving a deterministic bubble.
  - Flush overrides a simultaneous freeze.
- Freeze (without flush or rst): every output holds its value. No condition re-evaluation is captured.
- Load: every data field is registered with latency 1.
- Condition check is combinational on cond_in and status_in:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 treated as 0 (never).
- Condition false on load:
  - mem_read, mem_write, wb_en, branch and status_en are registered as 0; valid_out=0.
  - alu_cmd_out, data fields and carry_out are still captured.
- Condition true on load: control bits pass unchanged; valid_out=1.
- carry_out = status_in[1] (C) sampled on load.
- A bubble input (all control 0, alu_cmd 0) with true condition still gives valid_out=1. Valid means "not squashed", not "does work".
- Reset held mid-freeze or mid-flush clears everything; freeze resumes only after rst deasserts.

Optional Feature:
- Macro STATUS_FWD_EN.
- Defined: extra inputs ex_status_wr (1) and ex_status_val (4) are present.
  - When ex_status_wr=1, the condition check and carry_out use ex_status_val instead of status_in.
  - This resolves the case where the instruction in EX sets the flags in the same cycle.
- Undefined: those ports are absent. The hazard unit must freeze on a flag dependency.

Decomposition:
- Shared package arm_pkg holds:
  - condition code constants COND_EQ..COND_AL (4-bit)
  - ALU command encodings (MOV 0001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000, MVN 1001)
  - NZCV bit indices N=3, Z=2, C=1, V=0
- One sub-module: cond_check. Combinational, cond_in + flags -> cond_pass. Reused later by the WB-side status logic.

Test Plan:
- rst=1 for 2 cycles with all inputs 1 -> all outputs 0, valid_out=0. Deassert, load ADD (alu 0010, wb_en=1, cond AL) -> next cycle alu_cmd_out=0010, wb_en_out=1, valid_out=1.
- cond=EQ (0000), status=0100 (Z=1), STR (mem_write=1) -> mem_write_out=1. Repeat with status=0000 -> mem_write_out=0, valid_out=0, alu_cmd_out=0010.
- Load MOV, dest=5; assert freeze for 3 cycles while changing inputs to dest=9 -> dest_out stays 5 for 3 cycles, then becomes 9 one cycle after freeze drops.
- freeze=1 and flush=1 together with valid instruction held -> next edge all control outputs 0, valid_out=0.
- cond=GE, status N=1 V=1 -> pass; status N=1 V=0 -> fail. cond=1111 -> fail. ADC with C=1 -> carry_out=1.
- STATUS_FWD_EN defined: status_in Z=0, ex_status_wr=1, ex_status_val=0100, cond EQ, branch_in=1 -> branch_out=1. Same with ex_status_wr=0 -> branch_out=0.
